// File: rtl/ccc_fabric_clkdiv.sv
// rtl/ccc_fabric_clkdiv.sv - multi-channel fabric clock divider / CE generator with lock indication
// Define CCC_FABRIC_CLKDIV_CFG_ERR_EN to add the sticky CFG_ERR output for dropped configuration writes.
module ccc_fabric_clkdiv #(
   parameter int NUM_CH      = 4,
   parameter int CH_W        = 2,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 4,
   parameter int LOCK_CYCLES = 16
) (
   input  logic              FAB_CLK,
   input  logic              RESET,
   input  logic              CFG_WE,
   input  logic [CH_W-1:0]   CFG_CH,
   input  logic [DIV_W-1:0]  CFG_DIV,
   output logic              CFG_BUSY,
   output logic [NUM_CH-1:0] CE,
   output logic [NUM_CH-1:0] CLKOUT,
`ifdef CCC_FABRIC_CLKDIV_CFG_ERR_EN
   output logic              CFG_ERR,
`endif
   output logic              LOCK
);

   localparam int LCW = $clog2(LOCK_CYCLES + 1);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   logic [DIV_W-1:0]  cnt      [NUM_CH];
   logic [DIV_W-1:0]  div_act  [NUM_CH];
   logic [DIV_W-1:0]  div_pend [NUM_CH];
   logic [DIV_W-1:0]  div_m1   [NUM_CH];
   logic [DIV_W-1:0]  half_m1  [NUM_CH];
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] term;
   logic [NUM_CH-1:0] apply;
   logic [NUM_CH-1:0] ce_q;
   logic [NUM_CH-1:0] clk_q;

   logic        cfg_ch_ok;
   logic        cfg_accept;
   lock_state_t state_q, state_d;
   logic [LCW-1:0] lock_cnt_q, lock_cnt_d;

   assign cfg_ch_ok  = (int'(CFG_CH) < NUM_CH);
   assign cfg_accept = CFG_WE && !CFG_BUSY && cfg_ch_ok;
   assign CFG_BUSY   = |pend;

   // A disabled (D=0) or D=1 channel has no meaningful terminal to wait for, so pending values apply at once.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign div_m1[g]  = div_act[g] - DIV_W'(1);
      assign half_m1[g] = div_m1[g] >> 1;
      assign term[g]    = (div_act[g] != '0) && (cnt[g] == div_m1[g]);
      assign apply[g]   = pend[g] && ((div_act[g] < DIV_W'(2)) || term[g]);
   end

   always_ff @(posedge FAB_CLK) begin
      if (RESET) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]      <= '0;
            div_act[i]  <= DIV_W'(DEFAULT_DIV);
            div_pend[i] <= '0;
         end
         pend  <= '0;
         ce_q  <= '0;
         clk_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            ce_q[i] <= term[i];
            // Rise with the CE cycle, fall once ceil(D/2) high cycles have elapsed.
            if (div_act[i] == '0)
               clk_q[i] <= 1'b0;
            else if (term[i])
               clk_q[i] <= 1'b1;
            else if (cnt[i] == half_m1[i])
               clk_q[i] <= 1'b0;

            if (apply[i]) begin
               cnt[i]     <= '0;
               div_act[i] <= div_pend[i];
               pend[i]    <= 1'b0;
            end else if (term[i] || (div_act[i] == '0)) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + DIV_W'(1);
            end

            if (cfg_accept && (CFG_CH == CH_W'(i))) begin
               pend[i]     <= 1'b1;
               div_pend[i] <= CFG_DIV;
            end
         end
      end
   end

   assign CE     = ce_q;
   assign CLKOUT = clk_q;

   always_ff @(posedge FAB_CLK) begin
      if (RESET) begin
         state_q    <= UNLOCKED;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         UNLOCKED: begin
            if (!CFG_BUSY) begin
               if (lock_cnt_q != LCW'(LOCK_CYCLES))
                  lock_cnt_d = lock_cnt_q + LCW'(1);
               if (lock_cnt_q >= LCW'(LOCK_CYCLES - 1))
                  state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (cfg_accept) begin
               state_d    = UNLOCKED;
               lock_cnt_d = '0;
            end
         end
         default: begin
            state_d    = UNLOCKED;
            lock_cnt_d = '0;
         end
      endcase
   end

   assign LOCK = (state_q == LOCKED);

`ifdef CCC_FABRIC_CLKDIV_CFG_ERR_EN
   logic cfg_drop;
   logic cfg_err_q;

   assign cfg_drop = CFG_WE && !cfg_accept;

   always_ff @(posedge FAB_CLK) begin
      if (RESET)
         cfg_err_q <= 1'b0;
      else if (cfg_drop)
         cfg_err_q <= 1'b1;
   end

   assign CFG_ERR = cfg_err_q;
`endif

endmodule

// File: tb/tb_ccc_fabric_clkdiv.sv
// tb/tb_ccc_fabric_clkdiv.sv - self-checking bench for ccc_fabric_clkdiv with a behavioural reference model
module tb_ccc_fabric_clkdiv;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       we  = 1'b0;
   logic [2:0] ch  = '0;
   logic [7:0] div = '0;
   logic       busy;
   logic [3:0] ce;
   logic [3:0] clkout;
   logic       lock;
`ifdef CCC_FABRIC_CLKDIV_CFG_ERR_EN
   logic       cfg_err;
`endif

   int checks = 0;
   int fails  = 0;
   int cy     = 0;

   ccc_fabric_clkdiv #(
      .NUM_CH(4), .CH_W(3), .DIV_W(8), .DEFAULT_DIV(4), .LOCK_CYCLES(16)
   ) dut (
      .FAB_CLK (clk),
      .RESET   (rst),
      .CFG_WE  (we),
      .CFG_CH  (ch),
      .CFG_DIV (div),
      .CFG_BUSY(busy),
      .CE      (ce),
      .CLKOUT  (clkout),
`ifdef CCC_FABRIC_CLKDIV_CFG_ERR_EN
      .CFG_ERR (cfg_err),
`endif
      .LOCK    (lock)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t cycle=%0d)", name, act, exp, $time, cy);
      end
   endtask

   // Reference model: per-channel divide value, position in period and pending write.
   int         m_d [4];
   int         m_ph[4];
   int         m_pd[4];
   bit         m_started[4];
   logic [3:0] m_pend;
   bit         m_locked;
   int         m_lcnt;
   bit         mvalid = 0;
   logic [3:0] e_ce, e_clk;
   logic       e_err;

   task automatic model_step();
      bit busy_now, accept, drop, t;
      int d, p;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_d[i] = 4; m_ph[i] = 0; m_pd[i] = 0; m_started[i] = 0;
         end
         m_pend = '0; e_ce = '0; e_clk = '0; e_err = 1'b0;
         m_locked = 0; m_lcnt = 0; mvalid = 1;
      end else if (mvalid) begin
         busy_now = (m_pend != 0);
         accept   = we && !busy_now && (ch < 4);
         drop     = we && !accept;
         for (int i = 0; i < 4; i++) begin
            d = m_d[i];
            p = m_ph[i];
            t = (d != 0) && (p == d - 1);
            if (d == 0) begin
               e_ce[i] = 0; e_clk[i] = 0; m_started[i] = 0;
            end else if (t) begin
               e_ce[i] = 1; e_clk[i] = 1; m_started[i] = 1;
            end else begin
               e_ce[i]  = 0;
               e_clk[i] = m_started[i] && ((p + 1) < (d + 1) / 2);
            end
            if (m_pend[i] && (d < 2 || t)) begin
               m_d[i] = m_pd[i]; m_ph[i] = 0; m_pend[i] = 0;
            end else begin
               m_ph[i] = (d == 0 || t) ? 0 : p + 1;
            end
            if (accept && ch == 3'(i)) begin
               m_pend[i] = 1; m_pd[i] = int'(div);
            end
         end
         if (m_locked) begin
            if (accept) begin
               m_locked = 0; m_lcnt = 0;
            end
         end else if (!busy_now) begin
            m_lcnt++;
            if (m_lcnt >= 16) m_locked = 1;
         end
         if (drop) e_err = 1'b1;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         if (mvalid) begin
            chk("ce", 32'(ce), 32'(e_ce));
            chk("clkout", 32'(clkout), 32'(e_clk));
            chk("busy", 32'(busy), 32'(m_pend != 0));
            chk("lock", 32'(lock), 32'(m_locked));
`ifdef CCC_FABRIC_CLKDIV_CFG_ERR_EN
            chk("cfg_err", 32'(cfg_err), 32'(e_err));
`endif
         end
      end
   end

   task automatic go_to(input int c);
      while (cy < c) begin
         @(negedge clk);
         cy++;
      end
   endtask

   task automatic drive(input logic w, input logic [2:0] c, input logic [7:0] d);
      we = w; ch = c; div = d;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0; cy = 0;
      chk("pin_rst_ce", 32'(ce), 32'h0);
      chk("pin_rst_lock", 32'(lock), 32'h0);
      chk("pin_rst_busy", 32'(busy), 32'h0);
      go_to(3);  chk("pin_c3_ce", 32'(ce), 32'h0);
      go_to(4);  chk("pin_c4_ce", 32'(ce), 32'hf);
                 chk("pin_c4_clk", 32'(clkout), 32'hf);
      go_to(5);  chk("pin_c5_clk", 32'(clkout), 32'hf);
      go_to(6);  chk("pin_c6_clk", 32'(clkout), 32'h0);
      go_to(8);  chk("pin_c8_ce", 32'(ce), 32'hf);
      go_to(15); chk("pin_c15_lock", 32'(lock), 32'h0);
      go_to(16); chk("pin_c16_lock", 32'(lock), 32'h1);

      go_to(17); drive(1, 1, 6);
      go_to(18); chk("pin_wr_busy", 32'(busy), 32'h1);
                 chk("pin_wr_lock", 32'(lock), 32'h0);
                 drive(1, 2, 9);
      go_to(19); drive(1, 5, 9);
`ifdef CCC_FABRIC_CLKDIV_CFG_ERR_EN
                 chk("pin_err_set", 32'(cfg_err), 32'h1);
`endif
      go_to(20); drive(0, 0, 0);
                 chk("pin_apply_busy", 32'(busy), 32'h0);
                 chk("pin_oldterm_ce", 32'(ce), 32'hf);
      go_to(22); chk("pin_d6_clk_hi", 32'(clkout), 32'h2);
      go_to(23); chk("pin_d6_clk_lo", 32'(clkout), 32'h0);
      go_to(24); chk("pin_c24_ce", 32'(ce), 32'hd);
      go_to(26); chk("pin_c26_ce", 32'(ce), 32'h2);
      go_to(35); chk("pin_relock_early", 32'(lock), 32'h0);
      go_to(36); chk("pin_relock", 32'(lock), 32'h1);

      go_to(37); drive(1, 5, 3);
      go_to(38); drive(0, 0, 0);
                 chk("pin_oor_lock", 32'(lock), 32'h1);
                 chk("pin_oor_busy", 32'(busy), 32'h0);
      go_to(40); chk("pin_c40_ce", 32'(ce), 32'hd);

      go_to(41); drive(1, 3, 0);
      go_to(42); drive(0, 0, 0);
                 chk("pin_d0_busy", 32'(busy), 32'h1);
      go_to(44); chk("pin_d0_lastce", 32'(ce[3]), 32'h1);
      go_to(45); chk("pin_d0_clk", 32'(clkout[3]), 32'h0);
      go_to(48); chk("pin_d0_ce", 32'(ce), 32'h5);

      go_to(50); drive(1, 3, 1);
      go_to(51); drive(0, 0, 0);
      go_to(53); chk("pin_d1_ce", 32'(ce[3]), 32'h1);
                 chk("pin_d1_clk", 32'(clkout[3]), 32'h1);
      go_to(55); chk("pin_d1_ce_hold", 32'(ce[3]), 32'h1);

      go_to(56); drive(1, 0, 5);
      go_to(57); drive(0, 0, 0);
      go_to(60); chk("pin_d5_ce_a", 32'(ce[0]), 32'h1);
      go_to(64); chk("pin_d5_ce_gap", 32'(ce[0]), 32'h0);
      go_to(65); chk("pin_d5_ce_b", 32'(ce[0]), 32'h1);
      go_to(67); chk("pin_d5_clk_hi", 32'(clkout[0]), 32'h1);
      go_to(68); chk("pin_d5_clk_lo", 32'(clkout[0]), 32'h0);

      go_to(75); drive(1, 2, 7);
      go_to(76); drive(0, 0, 0);
                 chk("pin_mid_busy", 32'(busy), 32'h1);
                 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; cy = 0;
      chk("pin_mr_busy", 32'(busy), 32'h0);
      chk("pin_mr_ce", 32'(ce), 32'h0);
      chk("pin_mr_clk", 32'(clkout), 32'h0);
      chk("pin_mr_lock", 32'(lock), 32'h0);
      go_to(4);  chk("pin_mr_c4_ce", 32'(ce), 32'hf);
      go_to(15); chk("pin_mr_lock15", 32'(lock), 32'h0);
      go_to(16); chk("pin_mr_lock16", 32'(lock), 32'h1);

      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 199) == 0);
         we  = ($urandom_range(0, 3) == 0);
         ch  = 3'($urandom_range(0, 7));
         div = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      end
      @(negedge clk);
      rst = 1'b0; drive(0, 0, 0);
      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
